// File: rtl/insn_fetch_buffer_pkg.sv
// rtl/insn_fetch_buffer_pkg.sv - shared widths, NOP encoding and sizing helper for the fetch buffer
//
// Purpose : default geometry of the instruction fetch buffer and the instruction
//           presented to the converter when nothing real is available.
// Contents: DEF_PC_WIDTH, DEF_INSTR_WIDTH, DEF_FETCH_DEPTH, NOP_INSN, occ_width()
package insn_fetch_buffer_pkg;

    localparam int DEF_PC_WIDTH    = 32;
    localparam int DEF_INSTR_WIDTH = 32;
    localparam int DEF_FETCH_DEPTH = 4;

    // ori r0,r0,0 - the canonical no-op the converter sees while the buffer is empty
    localparam logic [31:0] NOP_INSN = 32'h6000_0000;

    // Occupancy counters must be able to hold DEPTH itself, hence one extra bit
    // over the pointer width.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/insn_fetch_buffer_fetch_fifo.sv
// rtl/insn_fetch_buffer_fetch_fifo.sv - DEPTH-entry FIFO holding {pc, instruction} pairs
//
// Purpose : storage for fetched words between instruction memory and the converter.
//           The head entry is visible combinationally on head_data.
// Ports   : clk, rst         clock, synchronous active-high reset
//           push, push_data  write one entry (ignored when full unless popping too)
//           pop              retire head entry (ignored when empty)
//           flush            drop all entries, takes priority over push/pop
//           head_data        oldest entry
//           full, empty      status
//           count            number of valid entries (0..DEPTH)
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits so they wrap for free.
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data array carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/insn_fetch_buffer.sv
// rtl/insn_fetch_buffer.sv - sequential instruction fetcher feeding the converter through a small FIFO
//
// Purpose : issues one word-aligned fetch per cycle while credit allows, queues the
//           returned words with their PCs and presents the oldest one to the converter,
//           holding it while either stall is raised. A redirect flushes everything.
// Ports   : clk, rst                      clock, synchronous active-high reset
//           redirect_valid, redirect_pc   flush and restart fetch at redirect_pc & ~3
//           imem_req, imem_addr           fetch request and word address
//           imem_rvalid, imem_rdata       response, exactly one cycle after the request
//           ext_stall, pipe_stall         hold the presented instruction
//           PC, dout, out_valid           presented instruction, its PC, and validity
module insn_fetch_buffer
    import insn_fetch_buffer_pkg::*;
#(
    parameter int DEPTH       = DEF_FETCH_DEPTH,
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   ext_stall,
    input  logic                   pipe_stall,
    output logic [PC_WIDTH-1:0]    PC,
    output logic [INSTR_WIDTH-1:0] dout,
    output logic                   out_valid
);

    localparam int CW = occ_width(DEPTH);
    localparam int EW = PC_WIDTH + INSTR_WIDTH;

    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]    last_pc_q, last_pc_d;
    logic                   inflight_q, inflight_d;

    logic [PC_WIDTH-1:0]    redirect_pc_aligned;
    logic                   req_ok;
    logic                   push, pop;
    logic [EW-1:0]          push_data;
    logic [EW-1:0]          head_data;
    logic [PC_WIDTH-1:0]    head_pc;
    logic [INSTR_WIDTH-1:0] head_insn;
    logic                   full, empty;
    logic [CW-1:0]          count;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign {head_pc, head_insn} = head_data;

    always_comb begin
        redirect_pc_aligned = redirect_pc & ~PC_WIDTH'(3);

        // An outstanding request already owns a slot, so occupancy plus inflight
        // can never exceed DEPTH and a response always has room to land.
        req_ok = !rst && !redirect_valid && ((count + CW'(inflight_q)) < CW'(DEPTH));

        imem_req  = req_ok;
        imem_addr = fetch_pc_q;

        // Only one request is ever outstanding and fetch_pc advanced by one word
        // when it issued, so the response belongs to fetch_pc - 4. Responses with
        // nothing outstanding (spurious or from before a redirect) are dropped.
        push      = imem_rvalid && inflight_q && !redirect_valid;
        push_data = {fetch_pc_q - PC_WIDTH'(4), imem_rdata};

        out_valid = !empty;
        // While empty, PC keeps the last retired value so the converter never
        // sees a PC change without a real instruction behind it.
        PC        = empty ? last_pc_q : head_pc;
        dout      = empty ? INSTR_WIDTH'(NOP_INSN) : head_insn;

        pop = out_valid && !ext_stall && !pipe_stall && !redirect_valid;

        fetch_pc_d = fetch_pc_q;
        last_pc_d  = last_pc_q;
        inflight_d = req_ok;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc_aligned;
            last_pc_d  = redirect_pc_aligned;
        end else begin
            if (req_ok) fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
            if (pop)    last_pc_d  = head_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= '0;
            last_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            last_pc_q  <= last_pc_d;
            inflight_q <= inflight_d;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_insn_fetch_buffer.sv
// tb/tb_insn_fetch_buffer.sv - self-checking bench for insn_fetch_buffer against a queue-based model
module tb_insn_fetch_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h6000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ext_stall = 1'b0;
    logic        pipe_stall = 1'b0;
    logic [31:0] PC;
    logic [31:0] dout;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    ent_t        mq[$];
    int          m_inflight = 0;
    logic [31:0] m_fetch_pc = '0, m_last_pc = '0, m_req_addr = '0;
    logic        exp_valid, exp_req;
    logic [31:0] exp_pc, exp_dout, exp_addr;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] mem_xor = '0;
    logic [97:0] got_v, exp_v;

    insn_fetch_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ext_stall      (ext_stall),
        .pipe_stall     (pipe_stall),
        .PC             (PC),
        .dout           (dout),
        .out_valid      (out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive inputs after the falling edge, let outputs settle,
    // record what the model expects, then advance the model past the rising edge.
    task automatic tick(input bit r, input bit rd, input logic [31:0] rpc,
                        input bit es, input bit ps, input bit sp);
        @(negedge clk);
        rst            = r;
        redirect_valid = rd;
        redirect_pc    = rpc;
        ext_stall      = es;
        pipe_stall     = ps;
        imem_rvalid    = pend || sp;
        imem_rdata     = pend ? (pend_addr ^ mem_xor) : $urandom;
        #1;
        exp_valid = (mq.size() != 0);
        exp_pc    = exp_valid ? mq[0].pc : m_last_pc;
        exp_dout  = exp_valid ? mq[0].instr : NOP;
        exp_req   = !r && !rd && ((mq.size() + m_inflight) < DEPTH);
        exp_addr  = m_fetch_pc;
        got_v     = {out_valid, PC, dout, imem_req, imem_addr};
        exp_v     = {exp_valid, exp_pc, exp_dout, exp_req, exp_addr};
        pend      = imem_req;
        pend_addr = imem_addr;
        if (r) begin
            mq.delete();
            m_inflight = 0;
            m_fetch_pc = '0;
            m_last_pc  = '0;
        end else if (rd) begin
            mq.delete();
            m_inflight = 0;
            m_fetch_pc = rpc & ~32'h3;
            m_last_pc  = rpc & ~32'h3;
        end else begin
            if (exp_valid && !es && !ps) begin
                m_last_pc = mq[0].pc;
                void'(mq.pop_front());
            end
            if (imem_rvalid && m_inflight == 1)
                mq.push_back('{pc: m_req_addr, instr: m_req_addr ^ mem_xor});
            if (exp_req) begin
                m_req_addr = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            m_inflight = exp_req ? 1 : 0;
        end
    endtask

    task automatic test_reset;
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", got_v, exp_v);
        end
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 0, 0, 0, 0);
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL t1_model k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            checks++;
            if (k < 2 && (out_valid !== 1'b0 || PC !== 32'h0 || dout !== NOP)) begin
                errors++;
                $display("FAIL t1_latency k=%0d got v=%b pc=%h d=%h exp v=0 pc=0 d=%h", k, out_valid, PC, dout, NOP);
            end else if (k >= 2 && (out_valid !== 1'b1 || PC !== 32'(4 * (k - 2)) || dout !== PC)) begin
                errors++;
                $display("FAIL t1_seq k=%0d got v=%b pc=%h d=%h exp v=1 pc=%h", k, out_valid, PC, dout, 32'(4 * (k - 2)));
            end
        end
    endtask

    task automatic test_stall;
        int n = 0;
        while (!(mq.size() != 0 && mq[0].pc == 32'h8) && n < 10) begin
            tick(0, 0, 0, 0, 0, 0);
            n++;
        end
        checks++;
        if (!(mq.size() != 0 && mq[0].pc == 32'h8)) begin
            errors++;
            $display("FAIL t2_reach_pc8 got head not 8 after %0d cycles exp head 8", n);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1, 0, 0);
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL t2_stall_model i=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            checks++;
            if (PC !== 32'h8 || dout !== 32'h8 || out_valid !== 1'b1 || (i == 2 && imem_req !== 1'b0)) begin
                errors++;
                $display("FAIL t2_hold i=%0d got pc=%h d=%h v=%b req=%b exp pc=8 d=8 v=1", i, PC, dout, out_valid, imem_req);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            checks++;
            if (got_v !== exp_v || out_valid !== 1'b1 || PC !== 32'(8 + 4 * i)) begin
                errors++;
                $display("FAIL t2_release i=%0d got=%h exp=%h exp_pc=%h", i, got_v, exp_v, 32'(8 + 4 * i));
            end
        end
    endtask

    task automatic test_redirect;
        logic [32:0] want [4] = '{{1'b0, 32'h100}, {1'b0, 32'h100}, {1'b1, 32'h100}, {1'b1, 32'h104}};
        int n = 0;
        while (!(mq.size() >= 3 && m_inflight == 1) && n < 10) begin
            tick(0, 0, 0, 0, 1, 0);
            n++;
        end
        checks++;
        if (!(mq.size() >= 3 && m_inflight == 1)) begin
            errors++;
            $display("FAIL t3_fill got size=%0d inflight=%0d exp size>=3 inflight=1", mq.size(), m_inflight);
        end
        tick(0, 1, 32'h103, 0, 1, 0);
        checks++;
        if (got_v !== exp_v || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL t3_redirect_cycle got=%h exp=%h", got_v, exp_v);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 0, i == 0);
            checks++;
            if (got_v !== exp_v || {out_valid, PC} !== want[i] || (i == 0 && (dout !== NOP || imem_addr !== 32'h100))) begin
                errors++;
                $display("FAIL t3_after i=%0d got=%h exp=%h want v/pc=%h", i, got_v, exp_v, want[i]);
            end
        end
    endtask

    task automatic test_redirect_stalled;
        logic [31:0] pc_hold;
        tick(0, 0, 0, 1, 1, 0);
        pc_hold = exp_pc;
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 1, 1, 0);
            checks++;
            if (got_v !== exp_v || PC !== pc_hold) begin
                errors++;
                $display("FAIL t4_stalled i=%0d got=%h exp=%h hold=%h", i, got_v, exp_v, pc_hold);
            end
        end
        tick(0, 1, 32'h200, 1, 1, 0);
        checks++;
        if (got_v !== exp_v || PC !== pc_hold) begin
            errors++;
            $display("FAIL t4_redirect_cycle got=%h exp=%h hold=%h", got_v, exp_v, pc_hold);
        end
        tick(0, 0, 0, 1, 1, 0);
        checks++;
        if (got_v !== exp_v || out_valid !== 1'b0 || PC !== 32'h200 || dout !== NOP) begin
            errors++;
            $display("FAIL t4_flushed got v=%b pc=%h d=%h exp v=0 pc=200 d=%h", out_valid, PC, dout, NOP);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL t4_resume i=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] nxt = 32'hFFFF_FFF8;
        int seen = 0;
        tick(0, 1, 32'hFFFF_FFF9, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            checks++;
            if (got_v !== exp_v || (out_valid === 1'b1 && PC !== nxt)) begin
                errors++;
                $display("FAIL t5_wrap i=%0d got=%h exp=%h exp_pc=%h", i, got_v, exp_v, nxt);
            end
            if (out_valid === 1'b1) begin
                nxt = nxt + 32'd4;
                seen++;
            end
        end
        checks++;
        if (seen < 4) begin
            errors++;
            $display("FAIL t5_count got %0d presented exp >=4", seen);
        end
    endtask

    task automatic test_spurious_and_reset;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1, 0, 1);
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL t6_spurious i=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        tick(1, 0, 0, 1, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (got_v !== exp_v || out_valid !== 1'b0 || dout !== NOP || PC !== 32'h0) begin
            errors++;
            $display("FAIL t6_mid_reset got v=%b pc=%h d=%h exp v=0 pc=0 d=%h", out_valid, PC, dout, NOP);
        end
    endtask

    task automatic test_random;
        mem_xor = $urandom;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            tick($urandom_range(0, 127) == 0, $urandom_range(0, 24) == 0, rpc,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random i=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset;
        test_stall;
        test_redirect;
        test_redirect_stalled;
        test_wrap;
        test_spurious_and_reset;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
